// File: rtl/run_sequencer.sv
// run_sequencer
//
// Host-side initiator for the processor's start/halt handshake and its data
// memory. One run does the following:
//   1. Streams an image into data memory (LOAD).
//   2. Holds the processor in start for START_CYC cycles (START).
//   3. Counts cycles until the processor halts or the timeout expires (RUN).
//   4. Streams a result window back out of data memory (DUMP).
// The block then parks in DONE until the next go.
//
// Ports
//   CLK          clock, rising edge
//   reset        synchronous, active-high; aborts to IDLE from any state
//   go           begin a run (sampled only in IDLE/DONE)
//   ld_valid     load byte valid
//   ld_ready     load byte accepted when ld_valid && ld_ready
//   ld_data      load byte
//   du_valid     dump byte valid
//   du_ready     dump byte consumed when du_valid && du_ready
//   du_data      dump byte
//   mem_own      1 = the mem_* outputs drive data memory, else the processor does
//   mem_addr     data memory address
//   mem_we       data memory write enable (LOAD only)
//   mem_wdata    data memory write data
//   mem_rdata    data memory read data, combinational from mem_addr
//   dut_start    processor start / hold-in-reset
//   dut_halt     processor halt
//   busy         state is neither IDLE nor DONE
//   done         run complete, held in DONE
//   timeout      last run was aborted by the timeout, held until next go
//   cycle_count  RUN cycles of the last/current run

module run_sequencer #(
  parameter int          AW        = 8,
  parameter int          LOAD_BASE = 0,
  parameter int          LOAD_LEN  = 256,
  parameter int          DUMP_BASE = 0,
  parameter int          DUMP_LEN  = 256,
  parameter int          START_CYC = 2,
  parameter logic [15:0] TIMEOUT   = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          go,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_data,
  output logic          du_valid,
  input  logic          du_ready,
  output logic [7:0]    du_data,
  output logic          mem_own,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          dut_start,
  input  logic          dut_halt,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [15:0]   cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE
  } state_t;

  // The index counter is wider than AW so that a full 2^AW-byte stream can
  // still be counted to its last element while the address wraps.
  localparam int            IW          = 17;
  localparam logic [IW-1:0] LOAD_LAST   = IW'(LOAD_LEN - 1);
  localparam logic [IW-1:0] DUMP_LAST   = IW'(DUMP_LEN - 1);
  localparam logic [IW-1:0] START_LAST  = IW'(START_CYC - 1);
  localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
  localparam logic [AW-1:0] DUMP_BASE_A = AW'(DUMP_BASE);

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [15:0]   cyc_q;
  logic          timeout_q;
  logic          go_start;
  logic          to_hit;

  assign cycle_count = cyc_q;
  assign timeout     = timeout_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode. go from IDLE or DONE starts a run; RUN exits
  // on halt first, so a halt that coincides with the timeout is not flagged.
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    du_valid  = 1'b0;
    du_data   = 8'h00;
    mem_own   = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    dut_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    go_start  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        dut_start = 1'b1;
        if (go) begin
          go_start  = 1'b1;
          state_nxt = (LOAD_LEN > 0) ? S_LOAD : S_START;
        end
      end
      S_LOAD: begin
        dut_start = 1'b1;
        mem_own   = 1'b1;
        ld_ready  = 1'b1;
        mem_we    = ld_valid;
        mem_wdata = ld_data;
        mem_addr  = LOAD_BASE_A + idx[AW-1:0];
        busy      = 1'b1;
        if (ld_valid && idx == LOAD_LAST) state_nxt = S_START;
      end
      S_START: begin
        dut_start = 1'b1;
        busy      = 1'b1;
        if (idx == START_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (dut_halt) begin
          state_nxt = (DUMP_LEN > 0) ? S_DUMP : S_DONE;
        end else if (cyc_q == TIMEOUT) begin
          to_hit    = 1'b1;
          state_nxt = (DUMP_LEN > 0) ? S_DUMP : S_DONE;
        end
      end
      S_DUMP: begin
        mem_own  = 1'b1;
        du_valid = 1'b1;
        du_data  = mem_rdata;
        mem_addr = DUMP_BASE_A + idx[AW-1:0];
        busy     = 1'b1;
        if (du_ready && idx == DUMP_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (go) begin
          go_start  = 1'b1;
          state_nxt = (LOAD_LEN > 0) ? S_LOAD : S_START;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Shared index: restarts at 0 on every state change, then counts accepted
  // load bytes, START cycles or dump handshakes depending on the state.
  always_ff @(posedge CLK) begin
    if (reset) begin
      idx <= '0;
    end else if (state_nxt != state) begin
      idx <= '0;
    end else if ((state == S_LOAD && ld_valid) || (state == S_DUMP && du_ready) ||
                 state == S_START) begin
      idx <= idx + 1'b1;
    end
  end

  // Run statistics: cleared by go, counted in RUN until halt or timeout.
  always_ff @(posedge CLK) begin
    if (reset) begin
      cyc_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else if (go_start) begin
      cyc_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else if (state == S_RUN && !dut_halt) begin
      if (to_hit) timeout_q <= 1'b1;
      else        cyc_q     <= cyc_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer
//
// Bench for run_sequencer with LOAD_LEN=4, DUMP_LEN=4, START_CYC=2, TIMEOUT=20.
// A behavioural data memory sits on the mem_* port. Expected memory writes and
// dump bytes are queued when the stimulus is issued; a negedge monitor pops and
// compares them whenever the DUT writes memory or completes a dump handshake.

module tb_run_sequencer;

  logic        CLK = 1'b0;
  logic        reset, go, ld_valid, du_ready, dut_halt;
  logic [7:0]  ld_data, du_data, mem_wdata, mem_rdata;
  logic        ld_ready, du_valid, mem_own, mem_we, dut_start, busy, done, timeout;
  logic [7:0]  mem_addr;
  logic [15:0] cycle_count;

  logic [7:0]  mem [256];
  logic [15:0] wrQ[$];
  logic [7:0]  duQ[$];
  int          checks = 0;
  int          passes = 0;
  int          ldAddr = 0;

  always #5 CLK = ~CLK;

  run_sequencer #(
    .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .DUMP_BASE(0), .DUMP_LEN(4),
    .START_CYC(2), .TIMEOUT(16'd20)
  ) dut (
    .CLK(CLK), .reset(reset), .go(go),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .du_valid(du_valid), .du_ready(du_ready), .du_data(du_data),
    .mem_own(mem_own), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dut_start(dut_start), .dut_halt(dut_halt),
    .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
  );

  // Data memory model: synchronous write, combinational read.
  always @(posedge CLK) begin
    if (mem_own && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic failEmpty(input string name);
    checks++;
    $display("[TB] FAIL %s: actual=event required=no event (queue empty)", name);
  endtask

  // Monitor: memory writes and dump handshakes against the scoreboard queues.
  logic [15:0] expWr;
  logic [7:0]  expDu;
  logic        stalled = 1'b0;
  logic [7:0]  heldData = 8'h00;
  always @(negedge CLK) begin
    if (mem_we) begin
      checkOutput("we_only_in_load", {31'd0, ld_ready}, 32'd1);
      if (wrQ.size() == 0) failEmpty("unexpected_write");
      else begin
        expWr = wrQ.pop_front();
        checkOutput("wr_addr", {24'd0, mem_addr}, {24'd0, expWr[15:8]});
        checkOutput("wr_data", {24'd0, mem_wdata}, {24'd0, expWr[7:0]});
      end
    end
    if (stalled && du_valid) checkOutput("du_stable", {24'd0, du_data}, {24'd0, heldData});
    if (du_valid && du_ready) begin
      if (duQ.size() == 0) failEmpty("unexpected_dump");
      else begin
        expDu = duQ.pop_front();
        checkOutput("du_data", {24'd0, du_data}, {24'd0, expDu});
      end
    end
    stalled  = du_valid && !du_ready;
    heldData = du_data;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulseGo;
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  // One load byte, optionally preceded by an idle (ld_valid=0) cycle.
  task automatic applyStimulus(input logic [7:0] b, input bit gap);
    if (gap) begin
      ld_valid = 1'b0;
      tick();
    end
    ld_valid = 1'b1;
    ld_data  = b;
    wrQ.push_back({8'(ldAddr), b});
    ldAddr++;
    tick();
    ld_valid = 1'b0;
  endtask

  // Drain DUMP with du_ready either following 1,0,0,1 or held high.
  task automatic runDump(input bit usePattern);
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    while (!done && k < 60) begin
      du_ready = usePattern ? pat[k % 4] : 1'b1;
      tick();
      k++;
    end
    du_ready = 1'b0;
    checkOutput("dump_reached_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; go = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    du_ready = 1'b0; dut_halt = 1'b0;
    tick(); tick();

    // Reset state
    checkOutput("rst_dut_start", {31'd0, dut_start}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mem_own", {31'd0, mem_own}, 32'd0);
    checkOutput("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    checkOutput("rst_du_valid", {31'd0, du_valid}, 32'd0);
    checkOutput("rst_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("rst_cycle_count", {16'd0, cycle_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Run 1: gapped load, halt after 10 RUN cycles, stalled dump
    ldAddr = 0;
    pulseGo();
    checkOutput("load_ld_ready", {31'd0, ld_ready}, 32'd1);
    checkOutput("load_mem_own", {31'd0, mem_own}, 32'd1);
    checkOutput("load_dut_start", {31'd0, dut_start}, 32'd1);
    applyStimulus(8'd11, 1'b1);
    applyStimulus(8'd22, 1'b1);
    applyStimulus(8'd33, 1'b1);
    applyStimulus(8'd44, 1'b1);
    duQ.push_back(8'd11); duQ.push_back(8'd22); duQ.push_back(8'd33); duQ.push_back(8'd44);
    checkOutput("start_c1_dut_start", {31'd0, dut_start}, 32'd1);
    checkOutput("start_c1_mem_own", {31'd0, mem_own}, 32'd0);
    checkOutput("start_c1_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("start_c2_dut_start", {31'd0, dut_start}, 32'd1);
    tick();
    checkOutput("run_dut_start", {31'd0, dut_start}, 32'd0);
    checkOutput("run_entry_count", {16'd0, cycle_count}, 32'd0);
    repeat (10) tick();
    dut_halt = 1'b1;
    tick();
    checkOutput("run1_cycle_count", {16'd0, cycle_count}, 32'd10);
    checkOutput("run1_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("run1_du_valid", {31'd0, du_valid}, 32'd1);
    runDump(1'b1);
    checkOutput("done1_busy", {31'd0, busy}, 32'd0);
    checkOutput("done1_dut_start", {31'd0, dut_start}, 32'd0);
    checkOutput("done1_mem_own", {31'd0, mem_own}, 32'd0);
    checkOutput("done1_cycle_count", {16'd0, cycle_count}, 32'd10);

    // Run 2: stale halt during START, halt never rises in RUN -> timeout
    ldAddr = 0;
    pulseGo();
    checkOutput("done_drops", {31'd0, done}, 32'd0);
    applyStimulus(8'd5, 1'b0);
    applyStimulus(8'd6, 1'b0);
    applyStimulus(8'd7, 1'b0);
    applyStimulus(8'd8, 1'b0);
    duQ.push_back(8'd5); duQ.push_back(8'd6); duQ.push_back(8'd7); duQ.push_back(8'd8);
    tick(); tick();
    dut_halt = 1'b0;
    checkOutput("run2_in_run", {30'd0, busy, dut_start}, {30'd0, 2'b10});
    checkOutput("run2_entry_count", {16'd0, cycle_count}, 32'd0);
    pulseGo();
    n = 1;
    while (!du_valid && n < 100) begin
      tick();
      n++;
    end
    checkOutput("run2_ticks_to_dump", n, 32'd21);
    checkOutput("run2_cycle_count", {16'd0, cycle_count}, 32'd20);
    checkOutput("run2_timeout", {31'd0, timeout}, 32'd1);
    runDump(1'b0);
    checkOutput("done2_timeout_held", {31'd0, timeout}, 32'd1);

    // Run 3: go clears stats, reset mid-load, then reload from base
    ldAddr = 0;
    pulseGo();
    checkOutput("go_clears_timeout", {31'd0, timeout}, 32'd0);
    checkOutput("go_clears_count", {16'd0, cycle_count}, 32'd0);
    applyStimulus(8'hA1, 1'b0);
    applyStimulus(8'hA2, 1'b0);
    reset = 1'b1;
    tick();
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_dut_start", {31'd0, dut_start}, 32'd1);
    ld_valid = 1'b1;
    #1;
    checkOutput("midrst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
    ld_valid = 1'b0;
    reset = 1'b0;
    tick();
    ldAddr = 0;
    pulseGo();
    applyStimulus(8'hC1, 1'b0);
    applyStimulus(8'hC2, 1'b0);
    applyStimulus(8'hC3, 1'b0);
    applyStimulus(8'hC4, 1'b0);
    duQ.push_back(8'hC1); duQ.push_back(8'hC2); duQ.push_back(8'hC3); duQ.push_back(8'hC4);
    tick(); tick();
    repeat (3) tick();
    dut_halt = 1'b1;
    tick();
    dut_halt = 1'b0;
    checkOutput("run3_cycle_count", {16'd0, cycle_count}, 32'd3);
    runDump(1'b1);

    checkOutput("wr_queue_drained", wrQ.size(), 32'd0);
    checkOutput("du_queue_drained", duQ.size(), 32'd0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
